// File: rtl/bp_nonsynth_cosim_sched_if.sv
// rtl/bp_nonsynth_cosim_sched_if.sv - commit-record and checker step channels of the cosim scheduler
interface bp_nonsynth_cosim_sched_if #(
  parameter int num_core_p  = 4,
  parameter int rec_width_p = 160
);
  localparam int hart_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  logic [num_core_p-1:0]             commit_v;
  logic [num_core_p*rec_width_p-1:0] commit_data;
  logic [num_core_p-1:0]             commit_yumi;
  logic                              step_v;
  logic [hart_w_lp-1:0]              step_hartid;
  logic [rec_width_p-1:0]            step_data;
  logic                              step_ready;
  logic                              step_fail;

  modport master (
    input  commit_v, commit_data, step_ready, step_fail,
    output commit_yumi, step_v, step_hartid, step_data
  );

  modport slave (
    output commit_v, commit_data, step_ready, step_fail,
    input  commit_yumi, step_v, step_hartid, step_data
  );
endinterface

// File: rtl/bp_nonsynth_cosim_sched.sv
// rtl/bp_nonsynth_cosim_sched.sv - round-robin commit-to-step scheduler with watchdog and end-of-test FSM
module bp_nonsynth_cosim_sched #(
  parameter int num_core_p    = 4,
  parameter int rec_width_p   = 160,
  parameter int stall_limit_p = 4096
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic [num_core_p-1:0] finish_i,
  bp_nonsynth_cosim_sched_if.master step_if,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  stall_o,
  output logic [63:0]           step_cnt_o
);
  localparam int hart_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam int wd_w_lp   = $clog2(stall_limit_p + 1);

  typedef enum logic [2:0] {e_idle, e_run, e_drain, e_pass, e_fail} state_e;

  state_e                 state_r, state_n;
  logic [num_core_p-1:0]  finish_r;
  logic [hart_w_lp-1:0]   ptr_r;
  logic                   buf_v_r;
  logic [hart_w_lp-1:0]   buf_hart_r;
  logic [rec_width_p-1:0] buf_data_r;
  logic [wd_w_lp-1:0]     wd_r;
  logic                   stall_r;

  logic                   run_drain, active, accept, step_fail_now, stall_trip, finish_all;
  logic                   grant_ok, grant_found, grant_v, set_stall;
  logic [hart_w_lp-1:0]   grant_idx;
  int                     cand, ptr_nxt;

  assign run_drain     = (state_r == e_run) || (state_r == e_drain);
  assign active        = run_drain && en_i;
  assign accept        = buf_v_r && step_if.step_ready;
  assign step_fail_now = run_drain && accept && step_if.step_fail;
  assign finish_all    = &(finish_r | finish_i);
  assign stall_trip    = active && !accept && (wd_r == wd_w_lp'(stall_limit_p - 1));

  // Search starts at the pointer and wraps; first valid hart wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < num_core_p; k++) begin
      cand = int'(ptr_r) + k;
      if (cand >= num_core_p) cand = cand - num_core_p;
      if (!grant_found && step_if.commit_v[cand]) begin
        grant_found = 1'b1;
        grant_idx   = hart_w_lp'(cand);
      end
    end
  end

  always_comb begin
    ptr_nxt = int'(grant_idx) + 1;
    if (ptr_nxt >= num_core_p) ptr_nxt = 0;
  end

  always_comb begin
    state_n   = state_r;
    grant_ok  = 1'b0;
    set_stall = 1'b0;
    case (state_r)
      e_idle: if (en_i) state_n = e_run;
      e_run, e_drain: begin
        if (step_fail_now) begin
          state_n = e_fail;
        end else if (stall_trip) begin
          state_n   = e_fail;
          set_stall = 1'b1;
        end else begin
          grant_ok = active;
          if (state_r == e_run) begin
            if (finish_all) state_n = e_drain;
          end else if (step_if.commit_v == '0 && (!buf_v_r || accept)) begin
            state_n = e_pass;
          end
        end
      end
      default: state_n = state_r;
    endcase
  end

  // The single output entry may be refilled in the same cycle it is accepted.
  assign grant_v = grant_ok && grant_found && (!buf_v_r || accept);

  always_comb begin
    step_if.commit_yumi = '0;
    if (grant_v) step_if.commit_yumi[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      finish_r   <= '0;
      ptr_r      <= '0;
      buf_v_r    <= 1'b0;
      buf_hart_r <= '0;
      buf_data_r <= '0;
      wd_r       <= '0;
      stall_r    <= 1'b0;
      step_cnt_o <= '0;
    end else begin
      state_r  <= state_n;
      finish_r <= finish_r | finish_i;
      if (grant_v) ptr_r <= hart_w_lp'(ptr_nxt);
      if (state_n == e_pass || state_n == e_fail) begin
        buf_v_r <= 1'b0;
      end else if (grant_v) begin
        buf_v_r    <= 1'b1;
        buf_hart_r <= grant_idx;
        buf_data_r <= step_if.commit_data[grant_idx*rec_width_p +: rec_width_p];
      end else if (accept) begin
        buf_v_r <= 1'b0;
      end
      if (accept) wd_r <= '0;
      else if (active) wd_r <= wd_r + 1'b1;
      if (set_stall) stall_r <= 1'b1;
      if (accept && run_drain && step_cnt_o != '1) step_cnt_o <= step_cnt_o + 64'd1;
    end
  end

  assign step_if.step_v      = buf_v_r;
  assign step_if.step_hartid = buf_hart_r;
  assign step_if.step_data   = buf_data_r;
  assign pass_o              = (state_r == e_pass);
  assign fail_o              = (state_r == e_fail);
  assign stall_o             = stall_r;
endmodule

// File: tb/tb_bp_nonsynth_cosim_sched.sv
// tb/tb_bp_nonsynth_cosim_sched.sv - scoreboard bench for the cosim step scheduler
module tb_bp_nonsynth_cosim_sched;
  localparam int n_lp   = 4;
  localparam int w_lp   = 160;
  localparam int lim_lp = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [n_lp-1:0] finish = '0;
  logic            pass, fail, stall;
  logic [63:0]     cnt;

  bp_nonsynth_cosim_sched_if #(.num_core_p(n_lp), .rec_width_p(w_lp)) bus ();

  bp_nonsynth_cosim_sched #(.num_core_p(n_lp), .rec_width_p(w_lp), .stall_limit_p(lim_lp)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .finish_i(finish), .step_if(bus),
    .pass_o(pass), .fail_o(fail), .stall_o(stall), .step_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  logic [w_lp-1:0] hq [n_lp][$];
  int              sb_h[$];
  logic [w_lp-1:0] sb_d[$];
  int              acc_hart[$];
  int              m_ptr, acc_cnt, seq;
  int              yumi_hist[n_lp];
  int              n_vec = 0, n_miss = 0;
  logic [n_lp-1:0] s_yumi;
  logic            s_v, s_acc, s_pass, s_fail;
  logic [1:0]      s_hart;
  logic [w_lp-1:0] s_data;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_commit();
    for (int i = 0; i < n_lp; i++) begin
      bus.commit_v[i] = (hq[i].size() != 0);
      bus.commit_data[i*w_lp +: w_lp] = (hq[i].size() != 0) ? hq[i][0] : '0;
    end
  endtask

  task automatic load(input int h, input int n);
    logic [w_lp-1:0] r;
    for (int j = 0; j < n; j++) begin
      r = {$urandom, $urandom, $urandom, $urandom, 16'(h), 16'(seq)};
      seq++;
      hq[h].push_back(r);
    end
    drive_commit();
  endtask

  // One clock: sample at negedge, predict grants from our own round-robin model.
  task automatic cycle();
    int pop_h, h, c;
    logic [n_lp-1:0] e;
    pop_h = -1;
    h = -1;
    @(negedge clk);
    s_yumi = bus.commit_yumi;
    s_v    = bus.step_v;
    s_hart = bus.step_hartid;
    s_data = bus.step_data;
    s_acc  = bus.step_v & bus.step_ready;
    s_pass = pass;
    s_fail = fail;
    for (int i = 0; i < n_lp; i++) if (s_yumi[i]) yumi_hist[i]++;
    if (s_yumi != '0) begin
      for (int k = 0; k < n_lp; k++) begin
        c = (m_ptr + k) % n_lp;
        if (h < 0 && hq[c].size() != 0) h = c;
      end
      if (h < 0) chk("yumi_spurious", s_yumi, 0);
      else begin
        e = 4'b0001 << h;
        chk("yumi_grant", s_yumi, e);
        sb_h.push_back(h);
        sb_d.push_back(hq[h][0]);
        pop_h = h;
        m_ptr = (h + 1) % n_lp;
      end
    end
    if (s_acc) begin
      acc_cnt++;
      acc_hart.push_back(int'(s_hart));
      chk("sb_nonempty", (sb_h.size() != 0), 1);
      if (sb_h.size() != 0) begin
        chk("step_hartid", s_hart, sb_h.pop_front());
        chk("step_data", s_data, sb_d.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (pop_h >= 0) void'(hq[pop_h].pop_front());
    drive_commit();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    finish = '0;
    bus.step_ready = 1'b0;
    bus.step_fail = 1'b0;
    for (int i = 0; i < n_lp; i++) begin
      hq[i].delete();
      yumi_hist[i] = 0;
    end
    sb_h.delete();
    sb_d.delete();
    acc_hart.delete();
    m_ptr = 0;
    acc_cnt = 0;
    drive_commit();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_accepts(input int target, input int budget, input string tag, output int cycles);
    cycles = 0;
    while (acc_cnt < target && cycles < budget) begin
      cycle();
      cycles++;
    end
    chk(tag, acc_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [w_lp-1:0] d0;
    seq = 0;

    // Reset state and fairness
    do_reset();
    chk("rst_step_v", bus.step_v, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", cnt, 0);
    for (int i = 0; i < n_lp; i++) load(i, 2);
    #1;
    chk("idle_yumi", bus.commit_yumi, 0);
    en = 1'b1;
    bus.step_ready = 1'b1;
    run_accepts(8, 30, "fair_acc", cyc);
    chk("fair_cycles", cyc, 10);
    for (int i = 0; i < 8; i++) if (acc_hart.size() > i) chk("fair_order", acc_hart[i], i % 4);
    chk("fair_cnt", cnt, 8);
    for (int i = 0; i < n_lp; i++) chk("fair_yumi_hist", yumi_hist[i], 2);

    // Backpressure with hart 2 pending
    do_reset();
    load(2, 2);
    d0 = hq[2][0];
    en = 1'b1;
    cycle();
    cycle();
    chk("bp_grant", s_yumi, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_v", s_v, 1);
      chk("bp_data", s_data, d0);
      chk("bp_yumi", s_yumi, 0);
    end
    bus.step_ready = 1'b1;
    cycle();
    chk("bp_acc", s_acc, 1);
    chk("bp_regrant", s_yumi, 4'b0100);
    cycle();
    chk("bp_cnt", cnt, 2);

    // Drain to pass
    do_reset();
    load(1, 3);
    finish = 4'hf;
    en = 1'b1;
    bus.step_ready = 1'b1;
    cyc = 0;
    while (acc_cnt < 3 && cyc < 20) begin
      cycle();
      cyc++;
      chk("drain_nopass", s_pass, 0);
    end
    chk("drain_acc", acc_cnt, 3);
    cycle();
    chk("drain_pass", s_pass, 1);
    chk("drain_v", s_v, 0);
    chk("drain_fail", s_fail, 0);
    cycle();
    chk("drain_pass_hold", s_pass, 1);
    chk("drain_v_hold", s_v, 0);

    // Checker mismatch on the 10th step
    do_reset();
    for (int i = 0; i < n_lp; i++) load(i, 4);
    en = 1'b1;
    bus.step_ready = 1'b1;
    cyc = 0;
    while (acc_cnt < 10 && cyc < 30) begin
      bus.step_fail = (acc_cnt == 9);
      cycle();
      cyc++;
    end
    bus.step_fail = 1'b0;
    chk("mm_acc", acc_cnt, 10);
    chk("mm_fail", fail, 1);
    chk("mm_stall", stall, 0);
    chk("mm_cnt", cnt, 10);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mm_yumi", s_yumi, 0);
      chk("mm_v", s_v, 0);
    end

    // Watchdog with no traffic
    do_reset();
    en = 1'b1;
    bus.step_ready = 1'b1;
    cycle();
    for (int k = 1; k <= 17; k++) begin
      cycle();
      chk("wd_fail", fail, (k >= 16));
    end
    chk("wd_stall", stall, 1);

    // Watchdog restarted by one accept at cycle 10
    do_reset();
    en = 1'b1;
    bus.step_ready = 1'b1;
    cycle();
    for (int k = 1; k <= 27; k++) begin
      if (k == 9) load(0, 1);
      cycle();
      chk("wd2_fail", fail, (k >= 26));
    end
    chk("wd2_stall", stall, 1);
    chk("wd2_cnt", cnt, 1);

    // Asynchronous reset in DRAIN with a full buffer
    do_reset();
    load(3, 2);
    finish = 4'hf;
    en = 1'b1;
    cycle();
    cycle();
    chk("ar_grant", s_yumi, 4'b1000);
    #2;
    chk("ar_v_pre", bus.step_v, 1);
    rst = 1'b1;
    #1;
    chk("ar_v", bus.step_v, 0);
    chk("ar_pass", pass, 0);
    chk("ar_fail", fail, 0);
    sb_h.delete();
    sb_d.delete();
    m_ptr = 0;
    finish = '0;
    load(0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.step_ready = 1'b1;
    cycle();
    chk("ar_idle_yumi", s_yumi, 0);
    cycle();
    chk("ar_first", s_yumi, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
